floor_request_scheduler: RTL and testbench
==========================================

# floor_request_scheduler

Front end of the elevator controller that captures floor call buttons and produces the `requested_floor` target the elevator state machine consumes. It latches button presses into a pending set and picks targets with a SCAN policy: keep going in the current direction, then reverse. It clears a request when the car reports it is stopped at that floor, then holds a door dwell period before issuing the next target.

## Interface
Parameters:
- `NUM_FLOORS`, default 10: number of floors/buttons, at most 16.
- `FLOOR_W`, default 4: width of floor numbers.
- `DWELL_CYCLES`, default 16: door-open hold time in clocks.
- `DEBOUNCE_CYCLES`, default 4: stable-input requirement, used only with the debounce macro.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `call_btn`  in  `NUM_FLOORS`: raw asynchronous buttons, active-high, bit i = floor i.
- `current_floor`  in  `FLOOR_W`: car position from the elevator state machine.
- `car_idle`  in  1: car stopped (elevator FSM in IDLE).
- `requested_floor`  out  `FLOOR_W`: target floor to the elevator state machine.
- `req_valid`  out  1: a target is being served.
- `pending`  out  `NUM_FLOORS`: latched outstanding requests.
- `door_open`  out  1: dwell in progress.

## Operation
- Button path, per floor:
  - 2-flop synchronizer, then rising-edge detect.
  - An edge sets `pending[i]`.
  - Holding a button pressed produces exactly one request.
- Direction register `dir` is UP or DOWN; reset value UP.
- FSM states:
  - **IDLE**: no pending requests. Go to SELECT when `pending` is nonzero.
  - **SELECT**: one cycle.
    - Search from `current_floor` in `dir`, inclusive of `current_floor`. Take the nearest set bit.
    - If none is found, flip `dir` and take the nearest set bit in the new direction.
    - Load `requested_floor`, set `req_valid`, go to SERVE.
  - **SERVE**:
    - When `current_floor == requested_floor && car_idle`: clear that pending bit, drop `req_valid`, load the dwell counter, go to DOOR.
    - A new request strictly between `current_floor` and the target, in direction `dir`, retargets `requested_floor` on the next cycle. This is the only retarget condition.
  - **DOOR**:
    - `door_open` is 1; count `DWELL_CYCLES`.
    - At expiry: go to SELECT if `pending` is nonzero, otherwise IDLE.
- While no target is held, `requested_floor` holds `current_floor`, so the elevator FSM stays idle.
- Simultaneous events:
  - An edge on the floor being cleared, in the same cycle as the clear: clear wins.
  - A press of `current_floor` during DOOR: not latched, and the dwell counter restarts.
- Buttons with index ≥ `NUM_FLOORS` do not exist.
- If `current_floor ≥ NUM_FLOORS`: treat the car as invalid. Force IDLE, hold `req_valid` at 0, and keep `pending` intact.
- Asserting reset mid-operation clears everything immediately, including the synchronizers.

## Timing
- Reset values: `requested_floor` 0, `req_valid` 0, `pending` 0, `door_open` 0, state IDLE, `dir` UP.
- Button rising edge to `pending[i]` set: 3 clocks (2 sync stages + edge register), with debounce disabled.
- `pending` set to `req_valid` high: 2 clocks (IDLE→SELECT, SELECT→SERVE).
- Arrival (`current_floor` match with `car_idle`) to `pending` bit clear and `door_open` high: 1 clock.
- `door_open` stays high for exactly `DWELL_CYCLES` clocks.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `FLOOR_SCHED_DEBOUNCE_EN` defined:
  - After synchronization, a button level must be stable for `DEBOUNCE_CYCLES` consecutive clocks before the edge detector sees it.
  - Press-to-pending latency becomes 3 + `DEBOUNCE_CYCLES` clocks.
  - Glitches shorter than that are ignored.
- Not defined: synchronizer plus edge detect only, and `DEBOUNCE_CYCLES` is unused.

## Structure
- Shared package `floor_sched_pkg` holds:
  - the FSM state enum (IDLE, SELECT, SERVE, DOOR);
  - direction constants UP/DOWN;
  - default `NUM_FLOORS`/`FLOOR_W` constants.
- Sub-module `button_conditioner`, one instance per floor via generate:
  - contains the synchronizer, the optional debounce counter and the edge detect;
  - outputs a single-cycle press pulse.
- The SCAN search is a combinational priority function inside the top module.

## Test plan
- Car at 0, idle; pulse `call_btn[3]` → `pending[3]` set after 3 clocks; `requested_floor`=3 and `req_valid`=1 2 clocks later.
- Car moving up from 0 toward 7, `dir` UP; press 4 while `current_floor`=2 → `requested_floor` retargets to 4. After arrival at 4 and the dwell, the target is 7.
- Pending {1,8} with car idle at 5 and `dir` UP → target 8 first, then `dir` flips and the target is 1.
- Hold `call_btn[2]` high for 100 clocks → `pending[2]` sets exactly once; after service it does not re-set until the button is released and pressed again.
- Car idle at 6 in DOOR; press 6 → no pending bit, `door_open` extended by a full `DWELL_CYCLES`. Assert reset mid-dwell → all outputs return to reset values within the same cycle.
- With `FLOOR_SCHED_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=4: a 2-clock glitch on `call_btn[5]` → no request; a 6-clock press → `pending[5]` set 7 clocks after the edge.

Source files
------------

// File: rtl/floor_sched_pkg.sv
// Shared types and constants for the floor request scheduler.
package floor_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SERVE,
    ST_DOOR
  } sched_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEFAULT_NUM_FLOORS = 10;
  localparam int DEFAULT_FLOOR_W    = 4;

endpackage

// File: rtl/button_conditioner.sv
// One call button: 2-flop synchronizer, optional debounce (FLOOR_SCHED_DEBOUNCE_EN),
// rising-edge detect producing a single-cycle press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef FLOOR_SCHED_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             db_level;

  // The filtered level only follows the synchronized input after it has
  // differed from it for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level   <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 == db_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      db_level   <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN floor request scheduler: latches call buttons and feeds targets to the elevator FSM.
// Defining FLOOR_SCHED_DEBOUNCE_EN adds a debounce filter to every button path.
module floor_request_scheduler
  import floor_sched_pkg::*;
#(
  parameter int NUM_FLOORS      = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W         = DEFAULT_FLOOR_W,
  parameter int DWELL_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic                  req_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD  = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  if (NUM_FLOORS < 1 || NUM_FLOORS > 16 || DWELL_CYCLES < 1 || (1 << FLOOR_W) < NUM_FLOORS)
  begin : g_bad_cfg
    $error("floor_request_scheduler: unsupported parameter set");
  end

  sched_state_t          state;
  logic                  dir;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] cur_hit;
  logic [NUM_FLOORS-1:0] door_mask;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] pending_next;
  logic                  cur_valid;
  logic                  arrive;
  logic                  door_press;
  logic [FLOOR_W:0]      fwd_hit;
  logic [FLOOR_W:0]      rev_hit;
  logic [FLOOR_W:0]      retarget_hit;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .reset(reset),
      .btn  (call_btn[i]),
      .press(press[i])
    );
  end

  // Nearest set bit inside [lo, hi]; returns {found, floor}.
  function automatic logic [FLOOR_W:0] nearest(input logic [NUM_FLOORS-1:0] req,
                                               input int lo, input int hi,
                                               input logic go_down);
    logic [FLOOR_W:0] hit;
    hit = '0;
    if (go_down) begin
      for (int i = 0; i < NUM_FLOORS; i++)
        if (req[i] && i >= lo && i <= hi) hit = {1'b1, FLOOR_W'(i)};
    end else begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--)
        if (req[i] && i >= lo && i <= hi) hit = {1'b1, FLOOR_W'(i)};
    end
    return hit;
  endfunction

  function automatic logic [FLOOR_W:0] scan_from(input logic [NUM_FLOORS-1:0] req,
                                                 input int from, input logic go_down);
    return go_down ? nearest(req, 0, from, 1'b1) : nearest(req, from, NUM_FLOORS - 1, 1'b0);
  endfunction

  always_comb begin
    cur_valid = ({1'b0, current_floor} < FLOOR_LIMIT);
    cur_hit   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) cur_hit[i] = (int'(current_floor) == i);

    arrive     = cur_valid && (state == ST_SERVE) && car_idle && (current_floor == requested_floor);
    door_mask  = (cur_valid && state == ST_DOOR) ? cur_hit : '0;
    clear_mask = arrive ? cur_hit : '0;
    door_press = |(press & door_mask);
    // A clear beats a same-cycle press of that floor; current-floor presses during DOOR are dropped.
    pending_next = (pending | (press & ~door_mask)) & ~clear_mask;

    fwd_hit = scan_from(pending, int'(current_floor), dir);
    rev_hit = scan_from(pending, int'(current_floor), ~dir);
    if (dir == DIR_UP)
      retarget_hit = nearest(press, int'(current_floor) + 1, int'(requested_floor) - 1, 1'b0);
    else
      retarget_hit = nearest(press, int'(requested_floor) + 1, int'(current_floor) - 1, 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      dir             <= DIR_UP;
      requested_floor <= '0;
      req_valid       <= 1'b0;
      door_open       <= 1'b0;
      dwell_cnt       <= '0;
      pending         <= '0;
    end else begin
      pending <= pending_next;
      if (!cur_valid) begin
        state           <= ST_IDLE;
        req_valid       <= 1'b0;
        door_open       <= 1'b0;
        requested_floor <= current_floor;
      end else begin
        case (state)
          ST_IDLE: begin
            requested_floor <= current_floor;
            if (|pending) state <= ST_SELECT;
          end
          ST_SELECT: begin
            if (fwd_hit[FLOOR_W]) begin
              requested_floor <= fwd_hit[FLOOR_W-1:0];
              req_valid       <= 1'b1;
              state           <= ST_SERVE;
            end else if (rev_hit[FLOOR_W]) begin
              dir             <= ~dir;
              requested_floor <= rev_hit[FLOOR_W-1:0];
              req_valid       <= 1'b1;
              state           <= ST_SERVE;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_SERVE: begin
            if (arrive) begin
              req_valid       <= 1'b0;
              door_open       <= 1'b1;
              dwell_cnt       <= DWELL_LOAD;
              requested_floor <= current_floor;
              state           <= ST_DOOR;
            end else if (retarget_hit[FLOOR_W]) begin
              requested_floor <= retarget_hit[FLOOR_W-1:0];
            end
          end
          ST_DOOR: begin
            requested_floor <= current_floor;
            if (door_press) begin
              dwell_cnt <= DWELL_LOAD;
            end else if (dwell_cnt == '0) begin
              door_open <= 1'b0;
              state     <= (|pending) ? ST_SELECT : ST_IDLE;
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard testbench for floor_request_scheduler (default parameters).
`timescale 1ns/1ps
module tb_floor_request_scheduler;

  localparam int NUM_FLOORS = 10;
  localparam int FLOOR_W    = 4;
  localparam int DWELL      = 16;
  localparam int DEBOUNCE   = 4;
`ifdef FLOOR_SCHED_DEBOUNCE_EN
  localparam int PRESS_LAT = 3 + DEBOUNCE;
`else
  localparam int PRESS_LAT = 3;
`endif

  localparam int K_PEND  = 0;
  localparam int K_REQ   = 1;
  localparam int K_VALID = 2;
  localparam int K_DOOR  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_FLOORS-1:0] call_btn;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  car_idle;
  logic [FLOOR_W-1:0]    requested_floor;
  logic                  req_valid;
  logic [NUM_FLOORS-1:0] pending;
  logic                  door_open;

  always #5 clk = ~clk;

  floor_request_scheduler #(
    .NUM_FLOORS     (NUM_FLOORS),
    .FLOOR_W        (FLOOR_W),
    .DWELL_CYCLES   (DWELL),
    .DEBOUNCE_CYCLES(DEBOUNCE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .call_btn       (call_btn),
    .current_floor  (current_floor),
    .car_idle       (car_idle),
    .requested_floor(requested_floor),
    .req_valid      (req_valid),
    .pending        (pending),
    .door_open      (door_open)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string tag;
    int    kind;
    int    exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  function automatic int observe(input int kind);
    case (kind)
      K_PEND:  return int'(pending);
      K_REQ:   return int'(requested_floor);
      K_VALID: return int'(req_valid);
      K_DOOR:  return int'(door_open);
      default: return -1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sbPush(input string tag, input int kind, input int exp);
    sb_entry_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sbCheck();
    sb_entry_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    checkOutput(e.tag, observe(e.kind), e.exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NUM_FLOORS-1:0] btn, input int floor, input logic idle);
    call_btn      = btn;
    current_floor = floor[FLOOR_W-1:0];
    car_idle      = idle;
  endtask

  task automatic waitFor(input string tag, input int kind, input int value, input int budget);
    int n;
    n = 0;
    while (observe(kind) != value && n < budget) begin
      cycles(1);
      n++;
    end
    if (observe(kind) != value) checkOutput({tag, "_timeout"}, observe(kind), value);
  endtask

  task automatic doReset(input int floor, input logic idle);
    applyStimulus('0, floor, idle);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int sets;
    int prev;
    int seen;

    // Reset values
    reset = 1'b1;
    applyStimulus('0, 0, 1'b1);
    cycles(2);
    sbPush("rst_req", K_REQ, 0);
    sbPush("rst_valid", K_VALID, 0);
    sbPush("rst_pend", K_PEND, 0);
    sbPush("rst_door", K_DOOR, 0);
    repeat (4) sbCheck();
    reset = 1'b0;
    cycles(1);

    // Press 3 with car idle at 0: latency, target, arrival and dwell
    applyStimulus(10'h008, 0, 1'b1);
    sbPush("t1_pend_early", K_PEND, 0);
    sbPush("t1_pend_set", K_PEND, 10'h008);
    sbPush("t1_valid_select", K_VALID, 0);
    sbPush("t1_valid", K_VALID, 1);
    sbPush("t1_req", K_REQ, 3);
    cycles(PRESS_LAT - 1); sbCheck();
    cycles(1); sbCheck();
    applyStimulus('0, 0, 1'b0);
    cycles(1); sbCheck();
    cycles(1); sbCheck(); sbCheck();
    applyStimulus('0, 1, 1'b0); cycles(1);
    applyStimulus('0, 2, 1'b0); cycles(1);
    applyStimulus('0, 3, 1'b1);
    sbPush("t1_door_open", K_DOOR, 1);
    sbPush("t1_pend_clear", K_PEND, 0);
    sbPush("t1_valid_drop", K_VALID, 0);
    cycles(1); sbCheck(); sbCheck(); sbCheck();
    n = 1;
    for (int k = 0; k < 100; k++) begin
      cycles(1);
      if (door_open) n++;
      else break;
    end
    checkOutput("t1_dwell_len", n, DWELL);
    sbPush("t1_idle_req", K_REQ, 3);
    cycles(1); sbCheck();

    // Retarget: heading to 7, press 4 at floor 2
    doReset(0, 1'b1);
    applyStimulus(10'h080, 0, 1'b1);
    sbPush("t2_pend7", K_PEND, 10'h080);
    sbPush("t2_req7", K_REQ, 7);
    sbPush("t2_pend47", K_PEND, 10'h090);
    sbPush("t2_retarget", K_REQ, 4);
    cycles(PRESS_LAT); sbCheck();
    applyStimulus('0, 0, 1'b0);
    cycles(2); sbCheck();
    applyStimulus('0, 1, 1'b0); cycles(1);
    applyStimulus(10'h010, 2, 1'b0);
    cycles(PRESS_LAT); sbCheck();
    applyStimulus('0, 2, 1'b0);
    cycles(1); sbCheck();
    applyStimulus('0, 3, 1'b0); cycles(1);
    applyStimulus('0, 4, 1'b1);
    sbPush("t2_door4", K_DOOR, 1);
    sbPush("t2_pend_after4", K_PEND, 10'h080);
    sbPush("t2_next_target", K_REQ, 7);
    cycles(1); sbCheck(); sbCheck();
    waitFor("t2_door_close", K_DOOR, 0, 3 * DWELL);
    waitFor("t2_next_valid", K_VALID, 1, 10);
    sbCheck();

    // SCAN order: pending {1,8}, car at 5 going up
    doReset(5, 1'b0);
    applyStimulus(10'h102, 5, 1'b0);
    sbPush("t3_pend", K_PEND, 10'h102);
    sbPush("t3_first", K_REQ, 8);
    sbPush("t3_pend_after8", K_PEND, 10'h002);
    sbPush("t3_reverse", K_REQ, 1);
    sbPush("t3_pend_behind", K_PEND, 10'h202);
    sbPush("t3_no_retarget", K_REQ, 1);
    sbPush("t3_down_retarget", K_REQ, 4);
    cycles(PRESS_LAT); sbCheck();
    applyStimulus('0, 5, 1'b0);
    cycles(2); sbCheck();
    applyStimulus('0, 6, 1'b0); cycles(1);
    applyStimulus('0, 7, 1'b0); cycles(1);
    applyStimulus('0, 8, 1'b1);
    cycles(1); sbCheck();
    waitFor("t3_door_close", K_DOOR, 0, 3 * DWELL);
    waitFor("t3_second_valid", K_VALID, 1, 10);
    sbCheck();
    applyStimulus(10'h200, 8, 1'b0);
    cycles(PRESS_LAT); sbCheck();
    applyStimulus('0, 8, 1'b0);
    cycles(1); sbCheck();
    applyStimulus(10'h010, 7, 1'b0);
    cycles(PRESS_LAT + 1); sbCheck();
    applyStimulus('0, 7, 1'b0);

    // Held button produces one request only
    doReset(0, 1'b0);
    applyStimulus(10'h004, 0, 1'b0);
    sets = 0;
    prev = 0;
    for (int i = 1; i <= 100; i++) begin
      cycles(1);
      if (i == 12) applyStimulus(10'h004, 2, 1'b1);
      if (((observe(K_PEND) >> 2) & 1) == 1 && prev == 0) sets++;
      prev = (observe(K_PEND) >> 2) & 1;
    end
    checkOutput("t4_single_set", sets, 1);
    checkOutput("t4_cleared_while_held", prev, 0);
    applyStimulus('0, 0, 1'b0);
    cycles(3);
    applyStimulus(10'h004, 0, 1'b0);
    sbPush("t4_repress", K_PEND, 10'h004);
    cycles(PRESS_LAT); sbCheck();
    applyStimulus('0, 0, 1'b0);

    // Press of the current floor during DOOR extends the dwell
    doReset(6, 1'b1);
    applyStimulus(10'h040, 6, 1'b1);
    cycles(PRESS_LAT);
    applyStimulus('0, 6, 1'b1);
    waitFor("t5_door", K_DOOR, 1, 10);
    cycles(4);
    applyStimulus(10'h040, 6, 1'b1);
    n = 0;
    seen = 0;
    for (int k = 1; k < 100; k++) begin
      cycles(1);
      if (k == PRESS_LAT) applyStimulus('0, 6, 1'b1);
      seen = seen | observe(K_PEND);
      if (door_open) n++;
      else break;
    end
    checkOutput("t5_door_extend", n, PRESS_LAT - 1 + DWELL);
    checkOutput("t5_no_latch", seen, 0);
    waitFor("t5_idle", K_DOOR, 0, 5);
    applyStimulus(10'h044, 6, 1'b1);
    cycles(PRESS_LAT);
    applyStimulus('0, 6, 1'b1);
    waitFor("t5_door2", K_DOOR, 1, 10);
    sbPush("t5_pend_keep2", K_PEND, 10'h004);
    sbPush("t5_req_hold", K_REQ, 6);
    sbCheck(); sbCheck();
    cycles(3);
    #2 reset = 1'b1;
    #1;
    sbPush("t5_rst_req", K_REQ, 0);
    sbPush("t5_rst_valid", K_VALID, 0);
    sbPush("t5_rst_pend", K_PEND, 0);
    sbPush("t5_rst_door", K_DOOR, 0);
    repeat (4) sbCheck();
    cycles(1);
    reset = 1'b0;
    cycles(1);

    // Invalid car position suspends service but keeps requests
    doReset(0, 1'b0);
    applyStimulus(10'h020, 0, 1'b0);
    cycles(PRESS_LAT);
    applyStimulus('0, 0, 1'b0);
    sbPush("t6_valid", K_VALID, 1);
    sbPush("t6_invalid_valid", K_VALID, 0);
    sbPush("t6_invalid_pend", K_PEND, 10'h020);
    sbPush("t6_still_invalid", K_VALID, 0);
    sbPush("t6_recover_valid", K_VALID, 1);
    sbPush("t6_recover_req", K_REQ, 5);
    cycles(2); sbCheck();
    applyStimulus('0, 12, 1'b0);
    cycles(1); sbCheck(); sbCheck();
    cycles(3); sbCheck();
    applyStimulus('0, 0, 1'b0);
    cycles(2); sbCheck(); sbCheck();

`ifdef FLOOR_SCHED_DEBOUNCE_EN
    // Short glitch rejected, long press accepted after 3 + DEBOUNCE clocks
    doReset(0, 1'b0);
    applyStimulus(10'h020, 0, 1'b0);
    cycles(2);
    applyStimulus('0, 0, 1'b0);
    sbPush("t7_glitch", K_PEND, 0);
    sbPush("t7_press_early", K_PEND, 0);
    sbPush("t7_press", K_PEND, 10'h020);
    cycles(12); sbCheck();
    applyStimulus(10'h020, 0, 1'b0);
    cycles(6); sbCheck();
    applyStimulus('0, 0, 1'b0);
    cycles(1); sbCheck();
`else
    // Without debounce a one-clock pulse is a valid press
    doReset(0, 1'b0);
    applyStimulus(10'h020, 0, 1'b0);
    cycles(1);
    applyStimulus('0, 0, 1'b0);
    sbPush("t7_short_press", K_PEND, 10'h020);
    cycles(2); sbCheck();
`endif

    checkOutput("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
